// File: rtl/gpio_reg_bank_p.sv
// ============================================================================
// Module   : gpio_reg_bank_p
// Purpose  : Parametrised GPIO register bank. Bus-visible registers for pad
//            output/enable, auxiliary output muxing, a 2-flop input
//            synchroniser with post-reset settle counter, per-pin edge
//            interrupts (rising / falling / both) with write-1-to-clear
//            status, and atomic OUT set/clear/toggle aliases.
// Ports    : sys_clk      - system clock, rising edge
//            sys_rst      - asynchronous reset, active low
//            gpio_addr    - register byte offset (ADDR_W bits)
//            gpio_dat_i   - write data (32)
//            gpio_we      - single-cycle write strobe
//            gpio_dat_o   - registered read data (32), 1-cycle latency
//            gpio_inta_o  - registered interrupt request
//            in_pad_i     - asynchronous pad inputs (WIDTH)
//            aux_i        - auxiliary output sources (WIDTH)
//            out_pad_o    - pad output values (WIDTH)
//            oen_padoe_o  - pad output enables, 1 = drive (WIDTH)
// Options  : GPIO_DEBOUNCE_EN - when defined, adds parameter DB_CYCLES and a
//            per-pin debounce filter between the synchroniser and IN / edge
//            detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_reg_bank_p #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DB_CYCLES = 4
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] gpio_addr,
    input  logic [31:0]       gpio_dat_i,
    input  logic              gpio_we,
    output logic [31:0]       gpio_dat_o,
    output logic              gpio_inta_o,
    input  logic [WIDTH-1:0]  in_pad_i,
    input  logic [WIDTH-1:0]  aux_i,
    output logic [WIDTH-1:0]  out_pad_o,
    output logic [WIDTH-1:0]  oen_padoe_o
);

    localparam logic [ADDR_W-1:0] c_ADDR_IN    = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] c_ADDR_OUT   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] c_ADDR_OE    = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] c_ADDR_INTE  = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] c_ADDR_PTRIG = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] c_ADDR_AUX   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL  = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] c_ADDR_INTS  = ADDR_W'(32'h1C);
    localparam logic [ADDR_W-1:0] c_ADDR_BOTH  = ADDR_W'(32'h20);
    localparam logic [ADDR_W-1:0] c_ADDR_OSET  = ADDR_W'(32'h24);
    localparam logic [ADDR_W-1:0] c_ADDR_OCLR  = ADDR_W'(32'h28);
    localparam logic [ADDR_W-1:0] c_ADDR_OTGL  = ADDR_W'(32'h2C);

    logic [WIDTH-1:0] r_out, r_oe, r_inte, r_ptrig, r_aux, r_ints, r_both;
    logic             r_ctrl0;
    logic [WIDTH-1:0] r_sync1, r_sync2, r_prev;
    logic [1:0]       r_settle;
    logic [31:0]      r_dat_o;
    logic             r_inta;

    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise, w_fall, w_evt;
    logic [WIDTH-1:0] w_w1c_mask;
    logic [WIDTH-1:0] w_ints_next;
    logic             w_settled;
    logic [31:0]      w_rdata;

    assign w_wd = gpio_dat_i[WIDTH-1:0];

    // Data bits above WIDTH have no backing storage.
    if (WIDTH < 32) begin : g_unused_hi
        logic w_unused_dat;
        assign w_unused_dat = ^gpio_dat_i[31:WIDTH];
    end

    // ------------------------------------------------------------------
    // Input synchroniser and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_settle <= 2'd0;
        end else begin
            r_sync1 <= in_pad_i;
            r_sync2 <= r_sync1;
            r_prev  <= w_in;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // Pins already high at reset release would otherwise look like a rising
    // edge once they reach the end of the synchroniser.
    assign w_settled = (r_settle == 2'd3);

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_DB_CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        logic [c_DB_CNT_W-1:0] r_cnt;
        logic                  r_filt;

        // The filtered value follows sync2 only after DB_CYCLES consecutive
        // differing samples; any agreement restarts the count.
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else if (r_sync2[gi] != r_filt) begin
                if (r_cnt == c_DB_CNT_W'(DB_CYCLES - 1)) begin
                    r_filt <= r_sync2[gi];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_in[gi] = r_filt;
    end
`else
    assign w_in = r_sync2;
`endif

    // ------------------------------------------------------------------
    // Edge detection and interrupt status
    // ------------------------------------------------------------------
    assign w_rise = w_in & ~r_prev;
    assign w_fall = ~w_in & r_prev;
    assign w_evt  = w_settled ? ((r_both & (w_rise | w_fall)) |
                                 (~r_both & r_ptrig & w_rise) |
                                 (~r_both & ~r_ptrig & w_fall))
                              : '0;

    assign w_w1c_mask  = (gpio_we && (gpio_addr == c_ADDR_INTS)) ? w_wd : '0;
    // A new event on a bit wins over a simultaneous clear of that bit.
    assign w_ints_next = (r_ints & ~w_w1c_mask) | (w_evt & r_inte);

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_out   <= '0;
            r_oe    <= '0;
            r_inte  <= '0;
            r_ptrig <= '0;
            r_aux   <= '0;
            r_both  <= '0;
            r_ctrl0 <= 1'b0;
            r_ints  <= '0;
            r_inta  <= 1'b0;
        end else begin
            r_ints <= w_ints_next;
            r_inta <= r_ctrl0 & (|w_ints_next);
            if (gpio_we) begin
                case (gpio_addr)
                    c_ADDR_OUT:   r_out   <= w_wd;
                    c_ADDR_OE:    r_oe    <= w_wd;
                    c_ADDR_INTE:  r_inte  <= w_wd;
                    c_ADDR_PTRIG: r_ptrig <= w_wd;
                    c_ADDR_AUX:   r_aux   <= w_wd;
                    c_ADDR_CTRL:  r_ctrl0 <= gpio_dat_i[0];
                    c_ADDR_BOTH:  r_both  <= w_wd;
                    c_ADDR_OSET:  r_out   <= r_out | w_wd;
                    c_ADDR_OCLR:  r_out   <= r_out & ~w_wd;
                    c_ADDR_OTGL:  r_out   <= r_out ^ w_wd;
                    default:      ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: loaded every cycle, so a read concurrent with a write
    // returns the value before the write.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (gpio_addr)
            c_ADDR_IN:    w_rdata = 32'(w_in);
            c_ADDR_OUT:   w_rdata = 32'(r_out);
            c_ADDR_OE:    w_rdata = 32'(r_oe);
            c_ADDR_INTE:  w_rdata = 32'(r_inte);
            c_ADDR_PTRIG: w_rdata = 32'(r_ptrig);
            c_ADDR_AUX:   w_rdata = 32'(r_aux);
            c_ADDR_CTRL:  w_rdata = {30'd0, |r_ints, r_ctrl0};
            c_ADDR_INTS:  w_rdata = 32'(r_ints);
            c_ADDR_BOTH:  w_rdata = 32'(r_both);
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_dat_o <= '0;
        end else begin
            r_dat_o <= w_rdata;
        end
    end

    assign gpio_dat_o  = r_dat_o;
    assign gpio_inta_o = r_inta;
    assign out_pad_o   = (r_out & ~r_aux) | (aux_i & r_aux);
    assign oen_padoe_o = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_gpio_reg_bank_p.sv
// ============================================================================
// Module   : tb_gpio_reg_bank_p
// Purpose  : Directed self-checking bench for gpio_reg_bank_p. A second
//            instance built with WIDTH = 8 shares the bus to check the
//            narrow-build read-back behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_reg_bank_p;

    localparam logic [7:0] c_IN    = 8'h00;
    localparam logic [7:0] c_OUT   = 8'h04;
    localparam logic [7:0] c_OE    = 8'h08;
    localparam logic [7:0] c_INTE  = 8'h0C;
    localparam logic [7:0] c_PTRIG = 8'h10;
    localparam logic [7:0] c_AUX   = 8'h14;
    localparam logic [7:0] c_CTRL  = 8'h18;
    localparam logic [7:0] c_INTS  = 8'h1C;
    localparam logic [7:0] c_BOTH  = 8'h20;
    localparam logic [7:0] c_OSET  = 8'h24;
    localparam logic [7:0] c_OCLR  = 8'h28;
    localparam logic [7:0] c_OTGL  = 8'h2C;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  gpio_addr;
    logic [31:0] gpio_dat_i;
    logic        gpio_we;
    logic [31:0] gpio_dat_o;
    logic        gpio_inta_o;
    logic [31:0] in_pad_i;
    logic [31:0] aux_i;
    logic [31:0] out_pad_o;
    logic [31:0] oen_padoe_o;

    logic [31:0] dat8_o;
    logic        inta8_o;
    logic [7:0]  in8_i;
    logic [7:0]  aux8_i;
    logic [7:0]  out8_o;
    logic [7:0]  oen8_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rd;

    always #5 sys_clk = ~sys_clk;

    gpio_reg_bank_p #(.WIDTH(32), .ADDR_W(8)) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .gpio_we     (gpio_we),
        .gpio_dat_o  (gpio_dat_o),
        .gpio_inta_o (gpio_inta_o),
        .in_pad_i    (in_pad_i),
        .aux_i       (aux_i),
        .out_pad_o   (out_pad_o),
        .oen_padoe_o (oen_padoe_o)
    );

    gpio_reg_bank_p #(.WIDTH(8), .ADDR_W(8)) u_dut8 (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .gpio_we     (gpio_we),
        .gpio_dat_o  (dat8_o),
        .gpio_inta_o (inta8_o),
        .in_pad_i    (in8_i),
        .aux_i       (aux8_i),
        .out_pad_o   (out8_o),
        .oen_padoe_o (oen8_o)
    );

    // All helpers start and end just after a falling clock edge.
    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        gpio_addr  = addr;
        gpio_dat_i = data;
        gpio_we    = 1'b1;
        @(negedge sys_clk);
        gpio_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr);
        gpio_addr = addr;
        gpio_we   = 1'b0;
        @(negedge sys_clk);
        rd = gpio_dat_o;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        n_vec++;
        if ({gpio_dat_o, out_pad_o, oen_padoe_o} !== 96'd0 || gpio_inta_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got dat=%h out=%h oe=%h inta=%b required all 0",
                     gpio_dat_o, out_pad_o, oen_padoe_o, gpio_inta_o);
        end
        sys_rst = 1'b1;
        bus_read(c_CTRL);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h required %h", rd, 32'h0);
        end
    endtask

    task automatic test_rw();
        bus_write(c_OUT, 32'hABCD_EF12);
        bus_read(c_OUT);
        n_vec++;
        if (rd !== 32'hABCD_EF12) begin
            n_err++;
            $display("FAIL rw_out_read: got %h required %h", rd, 32'hABCD_EF12);
        end
        n_vec++;
        if (out_pad_o !== 32'hABCD_EF12) begin
            n_err++;
            $display("FAIL rw_out_pad: got %h required %h", out_pad_o, 32'hABCD_EF12);
        end
        // Read in the same cycle as the write returns the old value.
        gpio_addr  = c_OE;
        gpio_dat_i = 32'h0000_00FF;
        gpio_we    = 1'b1;
        @(negedge sys_clk);
        gpio_we    = 1'b0;
        n_vec++;
        if (gpio_dat_o !== 32'h0) begin
            n_err++;
            $display("FAIL rw_pre_write: got %h required %h", gpio_dat_o, 32'h0);
        end
        @(negedge sys_clk);
        n_vec++;
        if (gpio_dat_o !== 32'h0000_00FF || oen_padoe_o !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL rw_oe: got dat=%h oe=%h required %h", gpio_dat_o, oen_padoe_o, 32'hFF);
        end
        bus_write(8'h30, 32'hFFFF_FFFF);
        bus_read(8'h30);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL rw_unmapped: got %h required %h", rd, 32'h0);
        end
        bus_read(c_OSET);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL rw_wo_read: got %h required %h", rd, 32'h0);
        end
    endtask

    task automatic test_set_clr_tgl();
        bus_write(c_OUT, 32'h0000_00F0);
        bus_write(c_OSET, 32'h0000_000F);
        bus_read(c_OUT);
        n_vec++;
        if (rd !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL out_set: got %h required %h", rd, 32'hFF);
        end
        bus_write(c_OCLR, 32'h0000_0030);
        bus_read(c_OUT);
        n_vec++;
        if (rd !== 32'h0000_00CF) begin
            n_err++;
            $display("FAIL out_clr: got %h required %h", rd, 32'hCF);
        end
        bus_write(c_OTGL, 32'h0000_0101);
        bus_read(c_OUT);
        n_vec++;
        if (rd !== 32'h0000_01CE) begin
            n_err++;
            $display("FAIL out_tgl: got %h required %h", rd, 32'h1CE);
        end
    endtask

    task automatic test_aux();
        bus_write(c_AUX, 32'hFFFF_0000);
        bus_write(c_OUT, 32'h1234_5678);
        aux_i = 32'h5454_4545;
        @(negedge sys_clk);
        n_vec++;
        if (out_pad_o !== 32'h5454_5678) begin
            n_err++;
            $display("FAIL aux_mux: got %h required %h", out_pad_o, 32'h5454_5678);
        end
        bus_write(c_AUX, 32'h0);
        aux_i = 32'h0;
    endtask

    task automatic test_width8();
        bus_write(c_OUT, 32'hFFFF_FFFF);
        bus_read(c_OUT);
        n_vec++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL w32_out: got %h required %h", rd, 32'hFFFF_FFFF);
        end
        n_vec++;
        if (dat8_o !== 32'h0000_00FF || out8_o !== 8'hFF) begin
            n_err++;
            $display("FAIL w8_out: got dat=%h pad=%h required %h / %h", dat8_o, out8_o, 32'hFF, 8'hFF);
        end
        bus_write(c_OUT, 32'h0);
    endtask

    task automatic test_irq_rise();
        bus_write(c_INTE, 32'h1);
        bus_write(c_PTRIG, 32'h1);
        bus_write(c_CTRL, 32'h1);
        in_pad_i[0] = 1'b1;
        gpio_addr   = c_IN;
        wait_cycles(2);
        n_vec++;
        if (gpio_inta_o !== 1'b0 || gpio_dat_o !== 32'h0) begin
            n_err++;
            $display("FAIL irq_early: got inta=%b in=%h required 0 / 0", gpio_inta_o, gpio_dat_o);
        end
        @(negedge sys_clk);
        n_vec++;
        if (gpio_inta_o !== 1'b1 || gpio_dat_o !== 32'h1) begin
            n_err++;
            $display("FAIL irq_assert: got inta=%b in=%h required 1 / 1", gpio_inta_o, gpio_dat_o);
        end
        bus_read(c_CTRL);
        n_vec++;
        if (rd !== 32'h3) begin
            n_err++;
            $display("FAIL irq_ctrl_pending: got %h required %h", rd, 32'h3);
        end
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h1) begin
            n_err++;
            $display("FAIL irq_ints: got %h required %h", rd, 32'h1);
        end
        bus_write(c_INTS, 32'h1);
        n_vec++;
        if (gpio_inta_o !== 1'b0) begin
            n_err++;
            $display("FAIL irq_w1c_inta: got %b required %b", gpio_inta_o, 1'b0);
        end
        in_pad_i[0] = 1'b0;
        wait_cycles(4);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL irq_fall_ignored: got %h required %h", rd, 32'h0);
        end
    endtask

    task automatic test_both_edges();
        bus_write(c_BOTH, 32'h8);
        bus_write(c_INTE, 32'h9);
        in_pad_i[3] = 1'b1;
        wait_cycles(4);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h8 || gpio_inta_o !== 1'b1) begin
            n_err++;
            $display("FAIL both_rise: got ints=%h inta=%b required %h / 1", rd, gpio_inta_o, 32'h8);
        end
        bus_write(c_INTS, 32'h8);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL both_clear: got %h required %h", rd, 32'h0);
        end
        in_pad_i[3] = 1'b0;
        wait_cycles(4);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h8) begin
            n_err++;
            $display("FAIL both_fall: got %h required %h", rd, 32'h8);
        end
        // W1C lands on the same clock edge as the next event on pin 3.
        in_pad_i[3] = 1'b1;
        wait_cycles(2);
        bus_write(c_INTS, 32'h8);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h8) begin
            n_err++;
            $display("FAIL both_set_wins: got %h required %h", rd, 32'h8);
        end
        bus_write(c_INTE, 32'h0);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h8) begin
            n_err++;
            $display("FAIL inte_keeps_ints: got %h required %h", rd, 32'h8);
        end
        bus_write(c_CTRL, 32'h0);
        @(negedge sys_clk);
        n_vec++;
        if (gpio_inta_o !== 1'b0) begin
            n_err++;
            $display("FAIL ctrl_gate_inta: got %b required %b", gpio_inta_o, 1'b0);
        end
        bus_write(c_INTS, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset_settle();
        bus_write(c_OUT, 32'h0000_00FF);
        bus_write(c_OE, 32'h0000_00FF);
        sys_rst  = 1'b0;
        in_pad_i = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if (out_pad_o !== 32'h0 || oen_padoe_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: got out=%h oe=%h required 0 / 0", out_pad_o, oen_padoe_o);
        end
        wait_cycles(2);
        sys_rst = 1'b1;
        bus_write(c_BOTH, 32'hFFFF_FFFF);
        bus_write(c_INTE, 32'hFFFF_FFFF);
        wait_cycles(5);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL settle_no_spurious: got %h required %h", rd, 32'h0);
        end
        in_pad_i = 32'h0;
        wait_cycles(4);
        bus_read(c_INTS);
        n_vec++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL settle_then_fall: got %h required %h", rd, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        gpio_addr  = 8'h0;
        gpio_dat_i = 32'h0;
        gpio_we    = 1'b0;
        in_pad_i   = 32'h0;
        aux_i      = 32'h0;
        in8_i      = 8'h0;
        aux8_i     = 8'h0;
        #2 sys_rst = 1'b0;

        test_reset();
        test_rw();
        test_set_clr_tgl();
        test_aux();
        test_width8();
        test_irq_rise();
        test_both_edges();
        test_reset_settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
